// File: rtl/i2c_reg16_slave.sv
// I2C target with a 16-bit register pointer and big-endian 16-bit data words.
// SCL/SDA are oversampled in the CLK_50 domain; SDA is driven open-drain only.
module i2c_reg16_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h0E,
    parameter int         HOLD_CYC   = 10
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        I2C_SCL,
    inout  wire         I2C_SDA,
    output logic [15:0] REG_ADDR,
    output logic [15:0] REG_WDATA,
    output logic        REG_WE,
    output logic        REG_RE,
    input  logic [15:0] REG_RDATA,
    output logic        BUSY,
    output logic [3:0]  ST
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ADDR       = 4'd1,
        S_ADDR_ACK   = 4'd2,
        S_PTR_HI     = 4'd3,
        S_PTR_HI_ACK = 4'd4,
        S_PTR_LO     = 4'd5,
        S_PTR_LO_ACK = 4'd6,
        S_WR_HI      = 4'd7,
        S_WR_HI_ACK  = 4'd8,
        S_WR_LO      = 4'd9,
        S_WR_LO_ACK  = 4'd10,
        S_RD_HI      = 4'd11,
        S_RD_HI_MACK = 4'd12,
        S_RD_LO      = 4'd13,
        S_RD_LO_MACK = 4'd14,
        S_WAIT       = 4'd15
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_scl_s1, r_scl_s2, r_scl_d;
    logic          r_sda_s1, r_sda_s2, r_sda_d;
    logic          w_start, w_stop, w_rise_ev, w_fall_ev;

    logic [2:0]    r_bitcnt;
    logic [6:0]    r_shift;
    logic [7:0]    w_byte;
    logic          w_last;
    logic          w_addr_hit;
    logic          r_rw;
    logic [7:0]    r_ptr_hi;
    logic [7:0]    r_wr_hi;
    logic [15:0]   r_ptr;
    logic [15:0]   r_wdata;
    logic          r_we;
    logic          r_re;
    logic          r_cap;
    logic [7:0]    r_tx;
    logic [7:0]    r_rd_lo;
    logic [HW-1:0] r_hold;
    logic          r_pend;
    logic          r_sda_oe;
    logic          w_pend;

    assign I2C_SDA   = r_sda_oe ? 1'b0 : 1'bz;
    assign REG_ADDR  = r_ptr;
    assign REG_WDATA = r_wdata;
    assign REG_WE    = r_we;
    assign REG_RE    = r_re;

    // Bus conditions; START/STOP mask any coincident SCL edge.
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_rise_ev  = r_scl_s2 & ~r_scl_d & ~w_start & ~w_stop;
    assign w_fall_ev  = ~r_scl_s2 & r_scl_d & ~w_start & ~w_stop;
    assign w_byte     = {r_shift, r_sda_s2};
    assign w_last     = (r_bitcnt == 3'd7);
    assign w_addr_hit = (w_byte[7:1] == SLAVE_ADDR);

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= I2C_SCL;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= I2C_SDA;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = S_ADDR;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_rise_ev) begin
            case (r_state)
                S_ADDR:       if (w_last) w_state_nxt = w_addr_hit ? S_ADDR_ACK : S_WAIT;
                S_ADDR_ACK:   w_state_nxt = r_rw ? S_RD_HI : S_PTR_HI;
                S_PTR_HI:     if (w_last) w_state_nxt = S_PTR_HI_ACK;
                S_PTR_HI_ACK: w_state_nxt = S_PTR_LO;
                S_PTR_LO:     if (w_last) w_state_nxt = S_PTR_LO_ACK;
                S_PTR_LO_ACK: w_state_nxt = S_WR_HI;
                S_WR_HI:      if (w_last) w_state_nxt = S_WR_HI_ACK;
                S_WR_HI_ACK:  w_state_nxt = S_WR_LO;
                S_WR_LO:      if (w_last) w_state_nxt = S_WR_LO_ACK;
                S_WR_LO_ACK:  w_state_nxt = S_WR_HI;
                S_RD_HI:      if (w_last) w_state_nxt = S_RD_HI_MACK;
                S_RD_HI_MACK: w_state_nxt = S_RD_LO;
                S_RD_LO:      if (w_last) w_state_nxt = S_RD_LO_MACK;
                S_RD_LO_MACK: w_state_nxt = r_sda_s2 ? S_WAIT : S_RD_HI;
                default:      w_state_nxt = r_state;
            endcase
        end
    end

    // Value SDA_OE takes HOLD_CYC cycles after an SCL fall seen in the current state.
    always_comb begin
        w_pend = 1'b0;
        BUSY   = (r_state != S_IDLE) && (r_state != S_ADDR) && (r_state != S_WAIT);
        ST     = r_state;
        case (r_state)
            S_ADDR_ACK, S_PTR_HI_ACK, S_PTR_LO_ACK,
            S_WR_HI_ACK, S_WR_LO_ACK: w_pend = 1'b1;
            S_RD_HI, S_RD_LO:         w_pend = ~r_tx[7];
            default:                  w_pend = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bitcnt <= 3'd0;
            r_rw     <= 1'b0;
            r_ptr    <= 16'h0000;
            r_wdata  <= 16'h0000;
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_cap    <= 1'b0;
            r_hold   <= '0;
            r_pend   <= 1'b0;
            r_sda_oe <= 1'b0;
        end else begin
            r_we  <= w_rise_ev && (r_state == S_WR_LO) && w_last;
            r_re  <= w_rise_ev && (((r_state == S_ADDR_ACK) && r_rw) ||
                                   ((r_state == S_RD_LO_MACK) && !r_sda_s2));
            r_cap <= r_re;

            if (w_start) begin
                r_bitcnt <= 3'd0;
            end else if (w_rise_ev) begin
                r_bitcnt <= (w_state_nxt != r_state) ? 3'd0 : r_bitcnt + 3'd1;
            end

            if (w_rise_ev && (r_state == S_ADDR) && w_last) r_rw <= w_byte[0];

            if (w_rise_ev && (r_state == S_WR_LO) && w_last) r_wdata <= {r_wr_hi, w_byte};

            // Pointer advances the cycle after the write strobe, or after a read lo byte.
            if (r_we) begin
                r_ptr <= r_ptr + 16'd2;
            end else if (w_rise_ev && (r_state == S_PTR_LO) && w_last) begin
                r_ptr <= {r_ptr_hi, w_byte};
            end else if (w_rise_ev && (r_state == S_RD_LO) && w_last) begin
                r_ptr <= r_ptr + 16'd2;
            end

            if (w_start || w_stop) begin
                r_hold   <= '0;
                r_sda_oe <= 1'b0;
            end else if (w_fall_ev) begin
                r_hold <= HW'(HOLD_CYC);
                r_pend <= w_pend;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - HW'(1);
                if (r_hold == HW'(1)) r_sda_oe <= r_pend;
            end
        end
    end

    always_ff @(posedge CLK_50) begin
        if (w_rise_ev) r_shift <= w_byte[6:0];
        if (w_rise_ev && (r_state == S_PTR_HI) && w_last) r_ptr_hi <= w_byte;
        if (w_rise_ev && (r_state == S_WR_HI) && w_last)  r_wr_hi  <= w_byte;

        if (r_cap) begin
            r_tx    <= REG_RDATA[15:8];
            r_rd_lo <= REG_RDATA[7:0];
        end else if (w_rise_ev) begin
            if ((r_state == S_RD_HI) || (r_state == S_RD_LO)) r_tx <= {r_tx[6:0], 1'b0};
            else if (r_state == S_RD_HI_MACK)                 r_tx <= r_rd_lo;
        end
    end

endmodule

// File: tb/tb_i2c_reg16_slave.sv
// Directed bench for i2c_reg16_slave: a bit-banged I2C master plus a strobe monitor.
module tb_i2c_reg16_slave;

    localparam int Q = 25;

    logic        clk;
    logic        rst_n;
    logic        m_scl;
    logic        m_sda_lo;
    wire         sda;
    logic [15:0] reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata;
    logic        busy;
    logic [3:0]  st;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    logic [15:0] we_addr_q[$];
    logic [15:0] we_data_q[$];
    logic [15:0] re_addr_q[$];

    pullup (sda);
    assign sda = m_sda_lo ? 1'b0 : 1'bz;

    // Register file model seen by the target.
    assign reg_rdata = (reg_addr == 16'h0000) ? 16'h4401 : (reg_addr ^ 16'hA5C3);

    i2c_reg16_slave #(.SLAVE_ADDR(7'h0E), .HOLD_CYC(10)) dut (
        .CLK_50   (clk),
        .RESET_N  (rst_n),
        .I2C_SCL  (m_scl),
        .I2C_SDA  (sda),
        .REG_ADDR (reg_addr),
        .REG_WDATA(reg_wdata),
        .REG_WE   (reg_we),
        .REG_RE   (reg_re),
        .REG_RDATA(reg_rdata),
        .BUSY     (busy),
        .ST       (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt++;
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (reg_re) begin
            re_cnt++;
            re_addr_q.push_back(reg_addr);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_lo = 1'b0; wait_clk(Q);
        m_scl    = 1'b1; wait_clk(Q);
        m_sda_lo = 1'b1; wait_clk(Q);
        m_scl    = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda_lo = 1'b1; wait_clk(Q);
        m_scl    = 1'b1; wait_clk(Q);
        m_sda_lo = 1'b0; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_lo = ~b; wait_clk(Q);
        m_scl    = 1'b1; wait_clk(2 * Q);
        m_scl    = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_lo = 1'b0; wait_clk(Q);
        m_scl    = 1'b1; wait_clk(Q);
        b        = sda;  wait_clk(Q);
        m_scl    = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        acked = ~b;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~mack);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_scl = 1'b1; m_sda_lo = 1'b0;
        wait_clk(4);
        checks++; if (st !== 4'd0)       begin errors++; $display("FAIL reset_st: got %0d expected 0", st); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({reg_we, reg_re} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {reg_we, reg_re}); end
        checks++; if (reg_addr !== 16'h0000 || reg_wdata !== 16'h0000) begin
            errors++; $display("FAIL reset_regs: got addr=%h wdata=%h expected 0000/0000", reg_addr, reg_wdata);
        end
        checks++; if (sda !== 1'b1)      begin errors++; $display("FAIL reset_sda: got %b expected 1", sda); end
        rst_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_word_write();
        logic a;
        int acks = 0;
        int base = we_cnt;
        i2c_start();
        write_byte(8'h1C, a); acks += int'(a);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ww_busy: got %b expected 1", busy); end
        write_byte(8'h00, a); acks += int'(a);
        write_byte(8'h04, a); acks += int'(a);
        write_byte(8'h80, a); acks += int'(a);
        write_byte(8'h47, a); acks += int'(a);
        i2c_stop();
        checks++; if (acks != 5) begin errors++; $display("FAIL ww_acks: got %0d expected 5", acks); end
        checks++; if (we_cnt - base != 1) begin errors++; $display("FAIL ww_we_count: got %0d expected 1", we_cnt - base); end
        checks++; if (we_addr_q[base] !== 16'h0004 || we_data_q[base] !== 16'h8047) begin
            errors++; $display("FAIL ww_we_word: got addr=%h data=%h expected 0004/8047", we_addr_q[base], we_data_q[base]);
        end
        checks++; if (reg_addr !== 16'h0006) begin errors++; $display("FAIL ww_ptr: got %h expected 0006", reg_addr); end
        checks++; if (st !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL ww_idle: got st=%0d busy=%b expected 0/0", st, busy); end
    endtask

    task automatic test_id_read();
        logic a;
        logic [7:0] hi, lo;
        int acks = 0;
        int base = re_cnt;
        i2c_start();
        write_byte(8'h1C, a); acks += int'(a);
        write_byte(8'h00, a); acks += int'(a);
        write_byte(8'h00, a); acks += int'(a);
        i2c_stop();
        i2c_start();
        write_byte(8'h1D, a); acks += int'(a);
        read_byte(1'b1, hi);
        read_byte(1'b0, lo);
        checks++; if (sda !== 1'b1 || st !== 4'd15 || busy !== 1'b0) begin
            errors++; $display("FAIL id_release: got sda=%b st=%0d busy=%b expected 1/15/0", sda, st, busy);
        end
        i2c_stop();
        checks++; if (acks != 4) begin errors++; $display("FAIL id_acks: got %0d expected 4", acks); end
        checks++; if (re_cnt - base != 1 || re_addr_q[base] !== 16'h0000) begin
            errors++; $display("FAIL id_re: got count=%0d addr=%h expected 1/0000", re_cnt - base, re_addr_q[base]);
        end
        checks++; if ({hi, lo} !== 16'h4401) begin errors++; $display("FAIL id_data: got %h expected 4401", {hi, lo}); end
        checks++; if (reg_addr !== 16'h0002) begin errors++; $display("FAIL id_ptr: got %h expected 0002", reg_addr); end
    endtask

    task automatic test_burst_wrap();
        logic a;
        int acks = 0;
        int base = we_cnt;
        i2c_start();
        write_byte(8'h1C, a); acks += int'(a);
        write_byte(8'hFF, a); acks += int'(a);
        write_byte(8'hFE, a); acks += int'(a);
        write_byte(8'h11, a); acks += int'(a);
        write_byte(8'h11, a); acks += int'(a);
        write_byte(8'h22, a); acks += int'(a);
        write_byte(8'h22, a); acks += int'(a);
        i2c_stop();
        checks++; if (acks != 7) begin errors++; $display("FAIL burst_acks: got %0d expected 7", acks); end
        checks++; if (we_cnt - base != 2) begin errors++; $display("FAIL burst_count: got %0d expected 2", we_cnt - base); end
        checks++; if (we_addr_q[base] !== 16'hFFFE || we_data_q[base] !== 16'h1111) begin
            errors++; $display("FAIL burst_first: got addr=%h data=%h expected FFFE/1111", we_addr_q[base], we_data_q[base]);
        end
        checks++; if (we_addr_q[base+1] !== 16'h0000 || we_data_q[base+1] !== 16'h2222) begin
            errors++; $display("FAIL burst_wrap: got addr=%h data=%h expected 0000/2222", we_addr_q[base+1], we_data_q[base+1]);
        end
        checks++; if (reg_addr !== 16'h0002) begin errors++; $display("FAIL burst_ptr: got %h expected 0002", reg_addr); end
    endtask

    task automatic test_addr_mismatch();
        logic a1, a2;
        int wb = we_cnt;
        int rb = re_cnt;
        i2c_start();
        write_byte(8'h1A, a1);
        checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL mm_nack: got ack=%b expected 0", a1); end
        checks++; if (busy !== 1'b0 || st !== 4'd15) begin errors++; $display("FAIL mm_state: got busy=%b st=%0d expected 0/15", busy, st); end
        write_byte(8'h1D, a2);
        write_byte(8'h00, a2);
        checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL mm_later_ack: got ack=%b expected 0", a2); end
        i2c_stop();
        checks++; if (we_cnt != wb || re_cnt != rb) begin
            errors++; $display("FAIL mm_strobes: got we=%0d re=%0d expected 0/0", we_cnt - wb, re_cnt - rb);
        end
    endtask

    task automatic test_abort();
        logic a;
        logic [7:0] hi, lo;
        int wb = we_cnt;
        int rb = re_cnt;
        // Data hi byte cut off by STOP, then a fresh read.
        i2c_start();
        write_byte(8'h1C, a); write_byte(8'h00, a); write_byte(8'h10, a); write_byte(8'hAB, a);
        i2c_stop();
        i2c_start();
        write_byte(8'h1D, a);
        read_byte(1'b1, hi);
        read_byte(1'b0, lo);
        i2c_stop();
        checks++; if ({hi, lo} !== 16'hA5D3) begin errors++; $display("FAIL abort_stop_data: got %h expected A5D3", {hi, lo}); end
        checks++; if (re_addr_q[rb] !== 16'h0010) begin errors++; $display("FAIL abort_stop_re: got %h expected 0010", re_addr_q[rb]); end
        // Data hi byte cut off by a repeated START.
        i2c_start();
        write_byte(8'h1C, a); write_byte(8'h00, a); write_byte(8'h20, a); write_byte(8'hAB, a);
        i2c_start();
        write_byte(8'h1D, a);
        read_byte(1'b1, hi);
        read_byte(1'b0, lo);
        i2c_stop();
        checks++; if ({hi, lo} !== 16'hA5E3) begin errors++; $display("FAIL abort_rs_data: got %h expected A5E3", {hi, lo}); end
        checks++; if (we_cnt != wb) begin errors++; $display("FAIL abort_no_we: got %0d expected 0", we_cnt - wb); end
        // Pointer hi byte alone must not move the pointer.
        i2c_start();
        write_byte(8'h1C, a); write_byte(8'h55, a);
        i2c_stop();
        checks++; if (reg_addr !== 16'h0022) begin errors++; $display("FAIL abort_ptr_hi_only: got %h expected 0022", reg_addr); end
    endtask

    task automatic test_back_to_back_read();
        logic a;
        logic [7:0] b0, b1, b2, b3;
        int rb = re_cnt;
        i2c_start();
        write_byte(8'h1D, a);
        read_byte(1'b1, b0);
        read_byte(1'b1, b1);
        read_byte(1'b1, b2);
        read_byte(1'b0, b3);
        i2c_stop();
        checks++; if ({b0, b1, b2, b3} !== 32'hA5E1A5E7) begin
            errors++; $display("FAIL b2b_data: got %h expected A5E1A5E7", {b0, b1, b2, b3});
        end
        checks++; if (re_cnt - rb != 2 || re_addr_q[rb] !== 16'h0022 || re_addr_q[rb+1] !== 16'h0024) begin
            errors++; $display("FAIL b2b_re: got count=%0d addrs=%h,%h expected 2/0022,0024",
                               re_cnt - rb, re_addr_q[rb], re_addr_q[rb+1]);
        end
        checks++; if (reg_addr !== 16'h0026) begin errors++; $display("FAIL b2b_ptr: got %h expected 0026", reg_addr); end
    endtask

    task automatic test_reset_mid_ack();
        logic a;
        int wb;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'h1C >> i));
        m_sda_lo = 1'b0;
        wait_clk(2);
        checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rma_ack_driven: got %b expected 0", sda); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rma_sda_release: got %b expected 1", sda); end
        checks++; if (st !== 4'd0 || busy !== 1'b0 || reg_we !== 1'b0 || reg_re !== 1'b0 ||
                      reg_addr !== 16'h0000 || reg_wdata !== 16'h0000) begin
            errors++; $display("FAIL rma_outputs: got st=%0d busy=%b we=%b re=%b addr=%h wdata=%h expected all zero",
                               st, busy, reg_we, reg_re, reg_addr, reg_wdata);
        end
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        i2c_stop();
        wb = we_cnt;
        i2c_start();
        write_byte(8'h1C, a); write_byte(8'h00, a); write_byte(8'h08, a);
        write_byte(8'h12, a); write_byte(8'h34, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rma_last_ack: got %b expected 1", a); end
        i2c_stop();
        checks++; if (we_cnt - wb != 1 || we_addr_q[wb] !== 16'h0008 || we_data_q[wb] !== 16'h1234) begin
            errors++; $display("FAIL rma_write: got count=%0d addr=%h data=%h expected 1/0008/1234",
                               we_cnt - wb, we_addr_q[wb], we_data_q[wb]);
        end
        checks++; if (reg_addr !== 16'h000A) begin errors++; $display("FAIL rma_ptr: got %h expected 000A", reg_addr); end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_id_read();
        test_burst_wrap();
        test_addr_mismatch();
        test_abort();
        test_back_to_back_read();
        test_reset_mid_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
